// File: rtl/int_square_seq_if.sv
// Start/ready handshake bundle shared by the sequential squaring and square-root units.
// The controller drives the master side; the arithmetic unit owns the slave side.
interface int_square_seq_if #(
    parameter int SIZE = 32
);
    logic                start;
    logic [SIZE-1:0]     num;
    logic                ready;
    logic [2*SIZE-1:0]   out;

    modport master (output start, output num, input ready, input out);
    modport slave  (input start, input num, output ready, output out);
endinterface

// File: rtl/int_square_seq.sv
// Sequential integer squarer: radix-2 shift-add of num*num over SIZE cycles,
// with fixed latency so it can share a controller with the square-root unit.
module int_square_seq #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    int_square_seq_if.slave   bus
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic {IDLE, CALC} state_e;

    state_e              state_q, state_d;
    logic [2*SIZE-1:0]   mcand_q, mcand_d;
    logic [SIZE-1:0]     mplier_q, mplier_d;
    logic [2*SIZE-1:0]   acc_q, acc_d;
    logic [2*SIZE-1:0]   out_q, out_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*SIZE-1:0]   sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final conditional add is folded into the value written to out,
    // so out only ever changes on the completion edge.
    always_comb begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d  = {{SIZE{1'b0}}, bus.num};
                    mplier_d = bus.num;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) out_d = sum;
            end
            default: ;
        endcase
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.out   = out_q;

endmodule

// File: tb/tb_int_square_seq.sv
// Directed and random checks of int_square_seq at SIZE=32 and SIZE=8 against
// an arithmetic reference (n*n) and the fixed SIZE-edge latency.
module tb_int_square_seq;

    logic clk;
    logic rstN;
    int   errors;
    int   checks;

    int_square_seq_if #(.SIZE(32)) b32 ();
    int_square_seq_if #(.SIZE(8))  b8 ();

    int_square_seq #(.SIZE(32)) dut32 (.clk(clk), .rst(rstN), .bus(b32.slave));
    int_square_seq #(.SIZE(8))  dut8  (.clk(clk), .rst(rstN), .bus(b8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] squareRef32(input logic [31:0] n);
        return 64'(n) * 64'(n);
    endfunction

    function automatic logic [15:0] squareRef8(input logic [7:0] n);
        return 16'(n) * 16'(n);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits at negedges for ready, counting posedges; bounded so a stuck DUT still ends.
    task automatic waitReady32(output int edges);
        edges = 0;
        while (b32.ready !== 1'b1 && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus32(input logic [31:0] n, input string tag);
        int edges;
        @(negedge clk);
        b32.start = 1'b1;
        b32.num   = n;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0;
        b32.num   = $urandom;
        checkOutput({tag, " ready low after accept"}, 64'(b32.ready), 64'd0);
        waitReady32(edges);
        checkOutput({tag, " latency"}, 64'(edges), 64'd32);
        checkOutput({tag, " out"}, b32.out, squareRef32(n));
    endtask

    initial begin
        int edges;
        int pulseSeen;
        logic [31:0] seq [3];
        logic [7:0] r;

        errors   = 0;
        checks   = 0;
        rstN     = 1'b0;
        b32.start = 1'b0;
        b32.num   = '0;
        b8.start  = 1'b0;
        b8.num    = '0;

        #12;
        checkOutput("reset ready", 64'(b32.ready), 64'd1);
        checkOutput("reset out", b32.out, 64'd0);
        checkOutput("reset ready8", 64'(b8.ready), 64'd1);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus32(32'd12345, "basic12345");
        checkOutput("basic12345 const", b32.out, 64'd152399025);
        applyStimulus32(32'd46341, "basic46341");
        checkOutput("basic46341 const", b32.out, 64'd2147488281);
        applyStimulus32(32'd0, "zero");
        applyStimulus32(32'd1, "one");
        applyStimulus32(32'hFFFF_FFFF, "max");
        checkOutput("max const", b32.out, 64'hFFFF_FFFE_0000_0001);

        // A start pulse during CALC must neither disturb out nor be queued.
        applyStimulus32(32'd7, "hold7");
        @(negedge clk);
        b32.start = 1'b1;
        b32.num   = 32'd9;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0;
        edges = 0;
        pulseSeen = 0;
        while (b32.ready !== 1'b1 && edges < 100) begin
            checkOutput("hold out during calc", b32.out, 64'd49);
            if (edges == 5) begin
                b32.start = 1'b1;
                b32.num   = 32'd5;
                pulseSeen = 1;
            end else begin
                b32.start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        b32.start = 1'b0;
        checkOutput("hold latency", 64'(edges), 64'd32);
        checkOutput("hold out 81", b32.out, squareRef32(32'd9));
        repeat (3) begin
            @(negedge clk);
            checkOutput("dropped request ready", 64'(b32.ready), 64'd1);
        end
        checkOutput("dropped request out", b32.out, 64'd81);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        b32.start = 1'b1;
        b32.num   = 32'd12345;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset out", b32.out, 64'd0);
        checkOutput("async reset ready", 64'(b32.ready), 64'd1);
        @(negedge clk);
        checkOutput("held reset out", b32.out, 64'd0);
        rstN = 1'b1;
        applyStimulus32(32'd3, "after reset");

        // Back-to-back with start held high; each operand presented just before its accept edge.
        seq[0] = 32'd2;
        seq[1] = 32'd3;
        seq[2] = 32'd4;
        @(negedge clk);
        b32.start = 1'b1;
        b32.num   = seq[0];
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            b32.num = $urandom;
            checkOutput("b2b ready low", 64'(b32.ready), 64'd0);
            waitReady32(edges);
            checkOutput("b2b latency", 64'(edges), 64'd32);
            checkOutput("b2b out", b32.out, squareRef32(seq[k]));
            if (k < 2) begin
                b32.num = seq[k+1];
                @(posedge clk);
            end else begin
                b32.start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                checkOutput("b2b idle after last", 64'(b32.ready), 64'd1);
                checkOutput("b2b final out", b32.out, 64'd16);
            end
        end

        // Random sweep on the 8-bit instance.
        for (int i = 0; i < 500; i++) begin
            r = 8'($urandom);
            if (i == 0) r = 8'hFF;
            @(negedge clk);
            b8.start = 1'b1;
            b8.num   = r;
            @(posedge clk);
            @(negedge clk);
            b8.start = 1'b0;
            b8.num   = 8'($urandom);
            checkOutput("rand8 ready low", 64'(b8.ready), 64'd0);
            edges = 0;
            while (b8.ready !== 1'b1 && edges < 40) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            checkOutput("rand8 latency", 64'(edges), 64'd8);
            checkOutput("rand8 out", 64'(b8.out), 64'(squareRef8(r)));
        end

        if (pulseSeen == 0) $display("[TB] note: mid-calc pulse not issued");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int_square_seq.md
Name: int_square_seq

Overview:
- Sequential integer squaring unit. It is the inverse-direction companion of the integer square-root unit in the FPU development tree.
- Computes num*num by radix-2 shift-add over SIZE cycles.
- Uses the same start/ready handshake as the square-root unit, so either unit can sit behind the same controller.
- Used to generate square-root test vectors and to check square-root results in hardware (r*r <= n < (r+1)*(r+1)).

Parameters:
- SIZE, 32, operand width in bits; result width is 2*SIZE.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, active-low, asynchronous.
- start  input  1  request. Sampled only while idle.
- num  input  SIZE  unsigned operand. Sampled on the edge that accepts start.
- ready  output  1  high while idle; out is valid whenever ready=1.
- out  output  2*SIZE  unsigned result register; holds the last completed square.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=1, out=0.
  - Internal operand, multiplier, accumulator and counter registers all clear to 0.
  - Reset asserted mid-calculation aborts the operation; no partial result reaches out.
- States: IDLE, CALC.
  - IDLE: ready=1. A rising edge with start=1 latches the following and moves to CALC; ready=0 from that edge:
    - multiplicand register (2*SIZE bits, zero-extended) = num
    - multiplier register (SIZE bits) = num
    - accumulator = 0
    - counter = 0
  - CALC, each edge:
    - If multiplier[0]=1, accumulator += multiplicand.
    - Multiplicand shifts left by 1; multiplier shifts right by 1; counter increments.
    - The accumulator is 2*SIZE bits wide and never overflows.
  - CALC, on the edge where counter==SIZE-1 (the SIZE-th CALC edge):
    - out is loaded with the final sum, including that edge's conditional add.
    - State returns to IDLE; ready=1 from that edge.
- Latency: ready rises exactly SIZE clock edges after the accepting edge. Acceptance to ready-high takes SIZE+1 cycles counting the accept cycle.
- out is written only on the completion edge. During CALC it holds the previous result, so downstream logic may read out at any time ready=1.
- start while in CALC is ignored; it is not queued.
- Back-to-back operation with start held high:
  - ready is high for exactly one cycle between operations.
  - The next operand is sampled on the edge following completion.
- num changing during CALC has no effect.
- num=0: all SIZE cycles still execute (fixed latency, no early exit); out=0.
- Counter width is clog2(SIZE), minimum 1 bit.
- Maximum operand: out = 2^(2*SIZE) - 2^(SIZE+1) + 1.

Test Plan:
- Reset: assert rst=0 mid-run with SIZE=32, num=12345 accepted and 10 cycles elapsed -> out=0 and ready=1 immediately (asynchronous); after rst=1, the next start with num=3 yields out=9.
- Basic and latency: start with num=12345 -> ready low the next cycle; ready high exactly 32 edges after the accept edge; out=152399025. Also num=46341 -> out=2147488281.
- Boundaries: num=0 -> out=0 after 32 cycles; num=1 -> out=1; num=0xFFFFFFFF -> out=0xFFFFFFFE00000001.
- Hold and ignore: start num=7 and complete (out=49); pulse start with num=5 during the next op on num=9 -> out stays 49 throughout CALC, then becomes 81; the num=5 request is dropped.
- Back-to-back: hold start=1 with num sequence 2,3,4 presented on accept edges -> out=4, 9, 16; each ready high exactly one cycle; period SIZE+1 cycles.
- Random sweep with SIZE=8: 500 random operands -> out equals num*num; latency is always 8 edges.
